preproc_source_select: RTL and testbench

Parametrised multi-channel source selector and DC-offset corrector at the head of the preprocessing stage. Per channel, it picks either live ADC samples or one of several internal test patterns (ramp, square tone, PRBS-15). It then subtracts a programmable signed offset and saturates the result to the ADC width. It runs in the ADC clock domain, and a simple register port writes and reads its configuration.

---
 rtl/preproc_source_select.sv | 222 ++++++++++++++++++++++
 tb/tb_preproc_source_select.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/preproc_source_select.sv
// preproc_source_select
//   Head of the preprocessing chain. For every channel it picks either the
//   live ADC sample or an internal test pattern (ramp, square tone, PRBS-15).
//   It then subtracts a programmable signed offset and saturates the result
//   back to the ADC width. Configuration is written and read through a simple
//   word-addressed register port that runs in the same clock domain.
//
// Ports
//   clk, rst             : ADC-domain clock, synchronous active-high reset
//   in_valid, in_data    : one signed sample per channel, ch k at [k*ADC_WIDTH +: ADC_WIDTH]
//   out_valid, out_data  : corrected samples, same packing, two cycles after input
//   cfg_we, cfg_re       : register write / read strobes
//   cfg_addr             : byte address, word index = cfg_addr[ADDR_WIDTH-1:2]
//   cfg_wdata, cfg_wstrb : write data and byte enables
//   cfg_rdata            : read data, updated the cycle after cfg_re and held otherwise
//
// Register map
//   word 0      CTRL     [2:0] source select, [31:16] square half period
//   word 1+k    OFFSET_k [15:0] signed offset for channel k
//   other words read 0, writes ignored

module preproc_source_select #(
  parameter int NUM_CH      = 2,
  parameter int ADC_WIDTH   = 14,
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 4,
  parameter int WSTRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic [NUM_CH*ADC_WIDTH-1:0] in_data,
  output logic                        out_valid,
  output logic [NUM_CH*ADC_WIDTH-1:0] out_data,
  input  logic                        cfg_we,
  input  logic                        cfg_re,
  input  logic [ADDR_WIDTH-1:0]       cfg_addr,
  input  logic [DATA_WIDTH-1:0]       cfg_wdata,
  input  logic [WSTRB_WIDTH-1:0]      cfg_wstrb,
  output logic [DATA_WIDTH-1:0]       cfg_rdata
);

  localparam int WORD_W = ADDR_WIDTH - 2;
  localparam int CH_W   = NUM_CH * ADC_WIDTH;
  localparam int DIFF_W = ADC_WIDTH + 2;

  localparam logic [ADC_WIDTH-1:0]     SQ_POS    = {1'b0, {(ADC_WIDTH-1){1'b1}}};
  localparam logic [ADC_WIDTH-1:0]     SQ_NEG    = {1'b1, {(ADC_WIDTH-2){1'b0}}, 1'b1};
  localparam logic signed [DIFF_W-1:0] SAT_HI    = {3'b000, {(ADC_WIDTH-1){1'b1}}};
  localparam logic signed [DIFF_W-1:0] SAT_LO    = {3'b111, {(ADC_WIDTH-1){1'b0}}};
  localparam logic [14:0]              PRBS_SEED = 15'h7FFF;

  // Rotate an ADC-width word left by k bit positions.
  function automatic logic [ADC_WIDTH-1:0] rotl(input logic [ADC_WIDTH-1:0] v, input int k);
    logic [ADC_WIDTH-1:0] r;
    r = {ADC_WIDTH{1'b0}};
    for (int i = 0; i < ADC_WIDTH; i++) begin
      r[(i + k) % ADC_WIDTH] = v[i];
    end
    return r;
  endfunction

  // Clamp a widened difference into the signed ADC range.
  function automatic logic [ADC_WIDTH-1:0] saturate(input logic signed [DIFF_W-1:0] d);
    logic [ADC_WIDTH-1:0] r;
    if (d > SAT_HI) begin
      r = SAT_HI[ADC_WIDTH-1:0];
    end else if (d < SAT_LO) begin
      r = SAT_LO[ADC_WIDTH-1:0];
    end else begin
      r = d[ADC_WIDTH-1:0];
    end
    return r;
  endfunction

  // One step of the x^15 + x^14 + 1 Fibonacci LFSR.
  function automatic logic [14:0] prbs_step(input logic [14:0] s);
    return {s[13:0], s[14] ^ s[13]};
  endfunction

  logic [WORD_W-1:0]            word_s;
  logic                         ctrl_wr_s;
  logic                         unused_addr_s;
  logic [DATA_WIDTH-1:0]        rd_word_s;
  logic [15:0]                  hp_eff_s;
  logic [CH_W-1:0]              src_s;
  logic [CH_W-1:0]              corr_s;

  logic [2:0]                   sel_r;
  logic [15:0]                  half_period_r;
  logic [NUM_CH-1:0][15:0]      offset_r;
  logic [ADC_WIDTH-1:0]         ramp_r;
  logic [15:0]                  sq_cnt_r;
  logic                         sq_neg_r;
  logic [14:0]                  prbs_r;
  logic                         vld_s1_r;
  logic [CH_W-1:0]              src_s1_r;
  logic [NUM_CH-1:0][15:0]      off_s1_r;

  assign word_s        = cfg_addr[ADDR_WIDTH-1:2];
  assign unused_addr_s = ^cfg_addr[1:0];
  // Any CTRL write with at least one byte enabled restarts the generators.
  assign ctrl_wr_s     = cfg_we & (word_s == {WORD_W{1'b0}}) & (|cfg_wstrb);
  assign hp_eff_s      = (half_period_r == 16'd0) ? 16'd1 : half_period_r;

  // Configuration registers with byte-enable writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_r         <= 3'd0;
      half_period_r <= 16'd0;
      offset_r      <= {(NUM_CH*16){1'b0}};
    end else if (cfg_we) begin
      if (word_s == {WORD_W{1'b0}}) begin
        if (cfg_wstrb[0]) sel_r               <= cfg_wdata[2:0];
        if (cfg_wstrb[2]) half_period_r[7:0]  <= cfg_wdata[23:16];
        if (cfg_wstrb[3]) half_period_r[15:8] <= cfg_wdata[31:24];
      end
      for (int k = 0; k < NUM_CH; k++) begin
        if (word_s == WORD_W'(k + 1)) begin
          if (cfg_wstrb[0]) offset_r[k][7:0]  <= cfg_wdata[7:0];
          if (cfg_wstrb[1]) offset_r[k][15:8] <= cfg_wdata[15:8];
        end
      end
    end
  end

  // Read mux: current register contents for the addressed word, zero if unmapped.
  always_comb begin
    rd_word_s = {DATA_WIDTH{1'b0}};
    if (word_s == {WORD_W{1'b0}}) begin
      rd_word_s[2:0]   = sel_r;
      rd_word_s[31:16] = half_period_r;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        rd_word_s[15:0] = (word_s == WORD_W'(k + 1)) ? offset_r[k] : rd_word_s[15:0];
      end
    end
  end

  // Read data register; holds between reads. A same-cycle write is not yet visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_rdata <= {DATA_WIDTH{1'b0}};
    end else if (cfg_re) begin
      cfg_rdata <= rd_word_s;
    end
  end

  // Pattern generators; they run on every accepted sample whatever source is selected.
  always_ff @(posedge clk) begin
    if (rst || ctrl_wr_s) begin
      ramp_r   <= {ADC_WIDTH{1'b0}};
      sq_cnt_r <= 16'd0;
      sq_neg_r <= 1'b0;
      prbs_r   <= PRBS_SEED;
    end else if (in_valid) begin
      ramp_r <= ramp_r + {{(ADC_WIDTH-1){1'b0}}, 1'b1};
      prbs_r <= prbs_step(prbs_r);
      // >= keeps the toggle bounded if HALF_PERIOD is lowered with a byte-masked write.
      if (sq_cnt_r >= (hp_eff_s - 16'd1)) begin
        sq_cnt_r <= 16'd0;
        sq_neg_r <= ~sq_neg_r;
      end else begin
        sq_cnt_r <= sq_cnt_r + 16'd1;
      end
    end
  end

  // Per-channel source selection from the current generator state.
  always_comb begin
    src_s = {CH_W{1'b0}};
    for (int k = 0; k < NUM_CH; k++) begin
      case (sel_r)
        3'd0:    src_s[k*ADC_WIDTH +: ADC_WIDTH] = in_data[k*ADC_WIDTH +: ADC_WIDTH];
        3'd1:    src_s[k*ADC_WIDTH +: ADC_WIDTH] = ramp_r + ADC_WIDTH'(k);
        3'd2:    src_s[k*ADC_WIDTH +: ADC_WIDTH] = sq_neg_r ? SQ_NEG : SQ_POS;
        3'd3:    src_s[k*ADC_WIDTH +: ADC_WIDTH] = rotl(ADC_WIDTH'(prbs_r), k);
        default: src_s[k*ADC_WIDTH +: ADC_WIDTH] = {ADC_WIDTH{1'b0}};
      endcase
    end
  end

  // Stage 1: capture the selected source together with the offsets in force
  // this cycle, so a write landing now only affects later samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_s1_r <= 1'b0;
      src_s1_r <= {CH_W{1'b0}};
      off_s1_r <= {(NUM_CH*16){1'b0}};
    end else begin
      vld_s1_r <= in_valid;
      if (in_valid) begin
        src_s1_r <= src_s;
        off_s1_r <= offset_r;
      end
    end
  end

  // Offset subtraction in ADC_WIDTH+2 bits followed by saturation.
  always_comb begin
    corr_s = {CH_W{1'b0}};
    for (int k = 0; k < NUM_CH; k++) begin
      corr_s[k*ADC_WIDTH +: ADC_WIDTH] =
        saturate(DIFF_W'($signed(src_s1_r[k*ADC_WIDTH +: ADC_WIDTH])) -
                 DIFF_W'($signed(off_s1_r[k])));
    end
  end

  // Stage 2: registered outputs; data holds while no sample is presented.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= {CH_W{1'b0}};
    end else begin
      out_valid <= vld_s1_r;
      if (vld_s1_r) begin
        out_data <= corr_s;
      end
    end
  end

endmodule

// File: tb/tb_preproc_source_select.sv
module tb_preproc_source_select;

  localparam int NUM_CH = 2;
  localparam int W      = 14;
  localparam int CH_W   = NUM_CH * W;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic [CH_W-1:0] in_data;
  logic            out_valid;
  logic [CH_W-1:0] out_data;
  logic            cfg_we;
  logic            cfg_re;
  logic [3:0]      cfg_addr;
  logic [31:0]     cfg_wdata;
  logic [3:0]      cfg_wstrb;
  logic [31:0]     cfg_rdata;

  always #5 clk = ~clk;

  preproc_source_select #(
    .NUM_CH(NUM_CH), .ADC_WIDTH(W), .DATA_WIDTH(32), .ADDR_WIDTH(4), .WSTRB_WIDTH(4)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data),
    .cfg_we(cfg_we), .cfg_re(cfg_re), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_wstrb(cfg_wstrb), .cfg_rdata(cfg_rdata)
  );

  int tests = 0;
  int fails = 0;
  logic [CH_W-1:0] exp_q[$];

  // Reference model: architectural register contents plus generator position.
  logic [31:0] m_ctrl;
  logic [15:0] m_off [NUM_CH];
  int          m_n;     // accepted samples since the last generator restart
  int          m_prbs;

  function automatic int wrap(input int x, input int bits);
    int m, r;
    m = 1 << bits;
    r = ((x % m) + m) % m;
    if (r >= m / 2) r = r - m;
    return r;
  endfunction

  function automatic logic [CH_W-1:0] pack(input int a, input int b);
    return {W'(b), W'(a)};
  endfunction

  function automatic logic [CH_W-1:0] model_out(input logic [CH_W-1:0] d);
    logic [CH_W-1:0]     r;
    logic signed [W-1:0] s14;
    logic signed [15:0]  o16;
    int src, dd, eff, lo;
    r   = '0;
    eff = (m_ctrl[31:16] == 16'd0) ? 1 : int'(m_ctrl[31:16]);
    lo  = m_prbs & 32'h3FFF;
    for (int k = 0; k < NUM_CH; k++) begin
      case (m_ctrl[2:0])
        3'd0: begin s14 = d[k*W +: W]; src = int'(s14); end
        3'd1: src = wrap(m_n + k, W);
        3'd2: src = (((m_n / eff) % 2) == 0) ? 8191 : -8191;
        3'd3: src = wrap(((lo << k) | (lo >> (W - k))) & 32'h3FFF, W);
        default: src = 0;
      endcase
      o16 = m_off[k];
      dd  = wrap(src - int'(o16), W + 2);
      if (dd > 8191) dd = 8191;
      else if (dd < -8192) dd = -8192;
      r[k*W +: W] = W'(dd);
    end
    return r;
  endfunction

  function automatic logic [31:0] model_read(input int word);
    if (word == 0) return m_ctrl & 32'hFFFF_0007;
    if (word >= 1 && word <= NUM_CH) return {16'h0000, m_off[word-1]};
    return 32'h0;
  endfunction

  task automatic model_write(input int word, input logic [31:0] wd, input logic [3:0] ws);
    logic [31:0] cur;
    if (word == 0) cur = m_ctrl;
    else if (word >= 1 && word <= NUM_CH) cur = {16'h0000, m_off[word-1]};
    else cur = 32'h0;
    for (int b = 0; b < 4; b++) if (ws[b]) cur[b*8 +: 8] = wd[b*8 +: 8];
    if (word == 0) m_ctrl = cur;
    else if (word >= 1 && word <= NUM_CH) m_off[word-1] = cur[15:0];
  endtask

  task automatic model_reset();
    m_ctrl = 32'h0;
    for (int k = 0; k < NUM_CH; k++) m_off[k] = 16'h0;
    m_n    = 0;
    m_prbs = 32'h7FFF;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  // One clock of stimulus. Expected output is queued from the model state
  // before this cycle's write/advance is applied.
  task automatic cycle(input logic v, input logic [CH_W-1:0] d, input logic we, input logic re,
                       input logic [3:0] addr, input logic [31:0] wd, input logic [3:0] ws,
                       input logic use_lit, input logic [CH_W-1:0] lit);
    logic [31:0] rexp;
    int fb;
    rexp      = 32'h0;
    in_valid  = v;
    in_data   = d;
    cfg_we    = we;
    cfg_re    = re;
    cfg_addr  = addr;
    cfg_wdata = wd;
    cfg_wstrb = ws;
    if (v) exp_q.push_back(use_lit ? lit : model_out(d));
    if (re) rexp = model_read(int'(addr[3:2]));
    if (we) model_write(int'(addr[3:2]), wd, ws);
    if (we && addr[3:2] == 2'd0 && ws != 4'h0) begin
      m_n    = 0;
      m_prbs = 32'h7FFF;
    end else if (v) begin
      m_n++;
      fb     = ((m_prbs >> 14) ^ (m_prbs >> 13)) & 1;
      m_prbs = ((m_prbs << 1) | fb) & 32'h7FFF;
    end
    @(posedge clk);
    #1;
    if (re) check("cfg_rdata", cfg_rdata, rexp);
  endtask

  task automatic smp();
    cycle(1'b1, CH_W'($urandom), 1'b0, 1'b0, 4'h0, 32'h0, 4'h0, 1'b0, '0);
  endtask
  task automatic lsmp(input logic [CH_W-1:0] d, input logic [CH_W-1:0] lit);
    cycle(1'b1, d, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0, 1'b1, lit);
  endtask
  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    cycle(1'b0, '0, 1'b1, 1'b0, a, d, s, 1'b0, '0);
  endtask
  task automatic rd(input logic [3:0] a);
    cycle(1'b0, '0, 1'b0, 1'b1, a, 32'h0, 4'h0, 1'b0, '0);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0, 1'b0, '0);
  endtask

  // Monitor: every presented output must match the oldest queued expectation.
  always @(negedge clk) begin
    logic [CH_W-1:0] e;
    if (out_valid === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_output: got %h with no sample outstanding", out_data);
      end else begin
        e = exp_q.pop_front();
        if (out_data !== e) begin
          fails++;
          $display("FAIL out_data: got %h, expected %h", out_data, e);
        end
      end
    end
  end

  initial begin
    logic [31:0] wd;
    logic [3:0]  a;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; cfg_we = 1'b0; cfg_re = 1'b0;
    cfg_addr = 4'h0; cfg_wdata = 32'h0; cfg_wstrb = 4'h0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_data", 32'(out_data), 32'h0);
    check("rst_cfg_rdata", cfg_rdata, 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) rd(4'(i * 4));

    // ADC pass-through, latency and back-to-back
    lsmp(pack(100, -200), pack(100, -200));
    check("latency_t1", 32'(out_valid), 32'h0);
    idle(1);
    check("latency_t2", 32'(out_valid), 32'h1);
    lsmp(pack(5, -7), pack(5, -7));
    lsmp(pack(-8192, 8191), pack(-8192, 8191));
    lsmp(pack(1, 2), pack(1, 2));
    check("b2b_1", 32'(out_valid), 32'h1);
    idle(1);
    check("b2b_2", 32'(out_valid), 32'h1);
    idle(1);
    check("b2b_end", 32'(out_valid), 32'h0);

    // Offsets and saturation
    wr(4'h4, 32'h0000_FF9C, 4'hF);
    wr(4'h8, 32'h0000_0064, 4'hF);
    lsmp(pack(8150, -8150), pack(8191, -8192));
    wr(4'h4, 32'd50, 4'h3);
    lsmp(pack(0, 0), pack(-50, -100));
    // write in the same cycle as a sample: old offset applies to that sample only
    cycle(1'b1, pack(10, 10), 1'b1, 1'b0, 4'h4, 32'd7, 4'h3, 1'b1, pack(-40, -90));
    lsmp(pack(10, 10), pack(3, -90));

    // Randomised ADC traffic with offset writes and reads
    for (int i = 0; i < 300; i++) begin
      a = 4'($urandom_range(4, 15));
      cycle(1'($urandom_range(0, 3) != 0), CH_W'($urandom), 1'($urandom_range(0, 9) == 0),
            1'($urandom_range(0, 9) == 0), a, $urandom, 4'($urandom), 1'b0, '0);
    end

    // Ramp
    wr(4'h4, 32'h0, 4'hF);
    wr(4'h8, 32'h0, 4'hF);
    wr(4'h0, 32'h1, 4'h1);
    for (int i = 0; i < 5; i++) lsmp(CH_W'($urandom), pack(i, i + 1));
    for (int i = 5; i < 16390; i++) begin
      if (i == 8191) lsmp(CH_W'($urandom), pack(8191, -8192));
      else if (i == 8192) lsmp(CH_W'($urandom), pack(-8192, -8191));
      else if (i == 16383) lsmp(CH_W'($urandom), pack(-1, 0));
      else smp();
    end

    // Square with HALF_PERIOD=3 and gaps between samples
    wr(4'h0, 32'h0003_0002, 4'hF);
    for (int i = 0; i < 9; i++) begin
      if (((i / 3) % 2) == 0) lsmp(CH_W'($urandom), pack(8191, 8191));
      else lsmp(CH_W'($urandom), pack(-8191, -8191));
      idle($urandom_range(0, 2));
    end
    // HALF_PERIOD=0 toggles every sample
    wr(4'h0, 32'h0000_0002, 4'hF);
    for (int i = 0; i < 4; i++)
      lsmp(CH_W'($urandom), (i % 2 == 0) ? pack(8191, 8191) : pack(-8191, -8191));
    // partial-strobe CTRL write still restarts
    wr(4'h0, 32'h0005_0000, 4'h4);
    for (int i = 0; i < 12; i++) smp();

    // PRBS-15, restart mid-sequence, then a full period
    wr(4'h0, 32'h3, 4'hF);
    lsmp(CH_W'($urandom), pack(-1, -1));
    for (int i = 0; i < 100; i++) smp();
    cycle(1'b1, CH_W'($urandom), 1'b1, 1'b0, 4'h0, 32'h3, 4'h1, 1'b0, '0);
    lsmp(CH_W'($urandom), pack(-1, -1));
    for (int i = 0; i < 32771; i++) smp();

    // Randomised everything
    for (int i = 0; i < 600; i++) begin
      a  = 4'($urandom);
      wd = $urandom;
      if (a[3:2] == 2'd0) wd[31:16] = 16'($urandom_range(0, 4));
      cycle(1'($urandom_range(0, 3) != 0), CH_W'($urandom), 1'($urandom_range(0, 6) == 0),
            1'($urandom_range(0, 6) == 0), a, wd, 4'($urandom), 1'b0, '0);
    end

    // Register port corners
    wr(4'h8, 32'h0, 4'hF);
    wr(4'h8, 32'h0000_ABCD, 4'b0001);
    rd(4'h8);
    check("offset1_partial", cfg_rdata, 32'h0000_00CD);
    wr(4'hC, 32'hFFFF_FFFF, 4'hF);
    rd(4'hC);
    check("unmapped_word3", cfg_rdata, 32'h0);
    wr(4'h4, 32'h0000_1111, 4'hF);
    cycle(1'b0, '0, 1'b1, 1'b1, 4'h4, 32'h0000_2222, 4'hF, 1'b0, '0);
    check("rw_same_word_old", cfg_rdata, 32'h0000_1111);
    rd(4'h4);
    idle(2);
    check("rdata_hold", cfg_rdata, 32'h0000_2222);

    // Reset mid-stream: the sample still in stage 1 is dropped
    smp(); smp(); smp();
    rst = 1'b1; in_valid = 1'b0; cfg_we = 1'b0; cfg_re = 1'b0;
    @(posedge clk);
    #1;
    exp_q.delete();
    check("midrst_out_valid", 32'(out_valid), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    check("midrst_out_valid2", 32'(out_valid), 32'h0);
    for (int i = 0; i < 4; i++) begin
      rd(4'(i * 4));
      check("post_rst_reg", cfg_rdata, 32'h0);
    end
    idle(3);

    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0) break;
      idle(1);
    end
    check("drain_queue_empty", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
